i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/i2c_arbiter.sv | 159 +++++++++++++++
 tb/tb_i2c_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the two-requester I2C arbiter: requester count and
// FSM state encodings.
package i2c_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, and on a tie the
// requester that was not served last wins.
module rr_arb2
  import i2c_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one byte-level I2C master between two requesters, handing out one
// transaction at a time with round-robin fairness and a transaction timeout.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TO_W    = 20
) (
  input  logic            CLK_100MHz,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [13:0]     req_addr,
  input  logic [NREQ-1:0] req_rw,
  input  logic [15:0]     req_wdata,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic [7:0]      rdata,
  output logic            err,
  output logic            busy,
  output logic [6:0]      m_addr,
  output logic [7:0]      m_data_in,
  output logic            m_rw,
  output logic            m_enable,
  input  logic [7:0]      m_data_out,
  input  logic            m_ready
);

  localparam logic [TO_W-1:0] TMR_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TMR_ONE  = TO_W'(1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q;
  logic [6:0]        m_addr_q, m_addr_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_rw_q, m_rw_d;
  logic              m_en_q, m_en_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              last_q, last_d;

  logic [NREQ-1:0]   arb_grant;
  logic              win;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant)
  );

  assign win = arb_grant[1];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = done_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    m_rw_d   = m_rw_q;
    m_en_d   = m_en_q;
    timer_d  = timer_q;
    last_d   = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if ((|req) && m_ready) begin
          grant_d  = arb_grant;
          m_addr_d = win ? req_addr[13:7]  : req_addr[6:0];
          m_data_d = win ? req_wdata[15:8] : req_wdata[7:0];
          m_rw_d   = win ? req_rw[1]       : req_rw[0];
          m_en_d   = 1'b1;
          timer_d  = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = timer_q + TMR_ONE;
        // The timeout wins over any m_ready activity in the same cycle.
        if (timer_q == TMR_LAST) begin
          m_en_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = ST_DONE;
        end else if (!m_ready) begin
          m_en_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TMR_ONE;
        if (timer_q == TMR_LAST) begin
          m_en_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = ST_DONE;
        end else if (m_ready) begin
          if (m_rw_q) begin
            rdata_d = m_data_out;
          end
          err_d   = 1'b0;
          done_d  = grant_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = '0;
        grant_d = '0;
        last_d  = grant_q[1];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      m_rw_q   <= 1'b0;
      m_en_q   <= 1'b0;
      timer_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      busy_q   <= (state_d != ST_IDLE);
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
      m_rw_q   <= m_rw_d;
      m_en_q   <= m_en_d;
      timer_q  <= timer_d;
      last_q   <= last_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign m_addr    = m_addr_q;
  assign m_data_in = m_data_q;
  assign m_rw      = m_rw_q;
  assign m_enable  = m_en_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scenario bench for i2c_arbiter: a behavioural byte master plus a queue of
// expected completions, drained as done pulses appear.
module tb_i2c_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req = '0;
  logic [13:0] req_addr = '0;
  logic [1:0]  req_rw = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  grant, done;
  logic [7:0]  rdata;
  logic        err, busy;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_in;
  logic        m_rw, m_enable;
  logic [7:0]  m_data_out = '0;
  logic        m_ready = 1'b1;

  logic [1:0]  req2 = '0;
  logic [13:0] req2_addr = '0;
  logic [1:0]  req2_rw = '0;
  logic [15:0] req2_wdata = '0;
  logic [1:0]  grant2, done2;
  logic [7:0]  rdata2;
  logic        err2, busy2;
  logic [6:0]  m_addr2;
  logic [7:0]  m_data_in2;
  logic        m_rw2, m_enable2;
  logic [7:0]  m_data_out2 = 8'h00;
  logic        m_ready2 = 1'b1;

  i2c_arbiter dut (
    .CLK_100MHz(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .err(err), .busy(busy), .m_addr(m_addr),
    .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
    .m_data_out(m_data_out), .m_ready(m_ready)
  );

  i2c_arbiter #(.TIMEOUT(64), .TO_W(20)) dut_to (
    .CLK_100MHz(clk), .rst(rst), .req(req2), .req_addr(req2_addr),
    .req_rw(req2_rw), .req_wdata(req2_wdata), .grant(grant2), .done(done2),
    .rdata(rdata2), .err(err2), .busy(busy2), .m_addr(m_addr2),
    .m_data_in(m_data_in2), .m_rw(m_rw2), .m_enable(m_enable2),
    .m_data_out(m_data_out2), .m_ready(m_ready2)
  );

  typedef struct {
    logic [1:0] owner;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  rd_hold = '0;

  // Byte master model: goes busy for mdl_lat cycles after seeing m_enable.
  int          mdl_lat = 4;
  int          mdl_cnt = 0;
  bit          mdl_force_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mdl_cnt = 0;
      m_ready = 1'b1;
    end else if (mdl_force_busy) begin
      m_ready = 1'b0;
    end else if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) m_ready = 1'b1;
    end else if (m_enable && m_ready) begin
      m_ready = 1'b0;
      mdl_cnt = mdl_lat;
    end else begin
      m_ready = 1'b1;
    end
  end

  task automatic wait_grant(input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (grant !== 2'b00) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({grant, done, err, busy, m_enable} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0000000", {grant, done, err, busy, m_enable});
    else n_pass++;
    n_chk++;
    if ({rdata, m_addr, m_data_in, m_rw} !== 24'b0)
      $display("FAIL reset_data got %h want 000000", {rdata, m_addr, m_data_in, m_rw});
    else n_pass++;
    n_chk++;
    if ({grant2, busy2, m_enable2} !== 4'b0)
      $display("FAIL reset_ctrl_to got %b want 0000", {grant2, busy2, m_enable2});
    else n_pass++;
    rst = 1'b0;
    rd_hold = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    bit hit;
    req_addr[6:0]  = 7'h3C;
    req_wdata[7:0] = 8'hA5;
    req_rw[0]      = 1'b0;
    mdl_lat        = 100;
    sb.push_back('{owner: 2'b01, addr: 7'h3C, wdata: 8'hA5, rdata: rd_hold, err: 1'b0});
    req = 2'b01;
    wait_grant(10, hit);
    n_chk++;
    if (!hit || grant !== 2'b01 || m_enable !== 1'b1 || busy !== 1'b1)
      $display("FAIL wr_grant got grant=%b en=%b busy=%b want 01 1 1", grant, m_enable, busy);
    else n_pass++;
    wait_done(300, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner)
      $display("FAIL wr_done got %b want %b", done, e.owner);
    else n_pass++;
    n_chk++;
    if (m_addr !== e.addr || m_data_in !== e.wdata || m_rw !== 1'b0)
      $display("FAIL wr_fields got %h/%h/%b want %h/%h/0", m_addr, m_data_in, m_rw, e.addr, e.wdata);
    else n_pass++;
    n_chk++;
    if (err !== e.err || rdata !== e.rdata || m_enable !== 1'b0)
      $display("FAIL wr_status got err=%b rdata=%h en=%b want %b %h 0", err, rdata, m_enable, e.err, e.rdata);
    else n_pass++;
    req = 2'b00;
    @(negedge clk);
    n_chk++;
    if ({done, grant, busy} !== 5'b0)
      $display("FAIL wr_release got %b want 00000", {done, grant, busy});
    else n_pass++;
  endtask

  task automatic test_single_read();
    bit hit;
    req_addr[13:7] = 7'h51;
    req_rw[1]      = 1'b1;
    m_data_out     = 8'h5A;
    mdl_lat        = 4;
    sb.push_back('{owner: 2'b10, addr: 7'h51, wdata: req_wdata[15:8], rdata: 8'h5A, err: 1'b0});
    req = 2'b10;
    wait_done(50, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner || rdata !== e.rdata)
      $display("FAIL rd_data got done=%b rdata=%h want %b %h", done, rdata, e.owner, e.rdata);
    else n_pass++;
    n_chk++;
    if (m_addr !== e.addr || m_rw !== 1'b1 || err !== e.err)
      $display("FAIL rd_fields got %h/%b/%b want %h/1/%b", m_addr, m_rw, err, e.addr, e.err);
    else n_pass++;
    rd_hold = 8'h5A;
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    bit hit;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_hold = '0;
    @(negedge clk);
    req_addr   = {7'h33, 7'h11};
    req_wdata  = {8'h44, 8'h22};
    req_rw     = 2'b10;
    m_data_out = 8'h77;
    mdl_lat    = 3;
    sb.push_back('{owner: 2'b01, addr: 7'h11, wdata: 8'h22, rdata: rd_hold, err: 1'b0});
    sb.push_back('{owner: 2'b10, addr: 7'h33, wdata: 8'h44, rdata: 8'h77, err: 1'b0});
    req = 2'b11;
    wait_grant(10, hit);
    n_chk++;
    if (!hit || grant !== 2'b01)
      $display("FAIL tie_first got %b want 01", grant);
    else n_pass++;
    wait_done(50, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner || m_addr !== e.addr || m_data_in !== e.wdata || rdata !== e.rdata)
      $display("FAIL tie_done0 got %b/%h/%h/%h want %b/%h/%h/%h",
               done, m_addr, m_data_in, rdata, e.owner, e.addr, e.wdata, e.rdata);
    else n_pass++;
    req = 2'b10;
    repeat (2) @(negedge clk);
    n_chk++;
    if (grant !== 2'b10)
      $display("FAIL tie_second_gap got %b want 10", grant);
    else n_pass++;
    wait_done(50, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner || m_addr !== e.addr || m_data_in !== e.wdata || rdata !== e.rdata)
      $display("FAIL tie_done1 got %b/%h/%h/%h want %b/%h/%h/%h",
               done, m_addr, m_data_in, rdata, e.owner, e.addr, e.wdata, e.rdata);
    else n_pass++;
    rd_hold = 8'h77;
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit hit;
    int cnt;
    req2_addr  = {7'h00, 7'h2A};
    req2_wdata = {8'h00, 8'hC3};
    req2_rw    = 2'b00;
    sb.push_back('{owner: 2'b01, addr: 7'h2A, wdata: 8'hC3, rdata: 8'h00, err: 1'b1});
    req2 = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant2 !== 2'b00) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit || grant2 !== 2'b01 || m_enable2 !== 1'b1)
      $display("FAIL to_grant got grant=%b en=%b want 01 1", grant2, m_enable2);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (done2 !== 2'b00) break;
    end
    e = sb.pop_front();
    n_chk++;
    if (cnt != 64 || done2 !== e.owner)
      $display("FAIL to_latency got %0d cycles done=%b want 64 %b", cnt, done2, e.owner);
    else n_pass++;
    n_chk++;
    if (err2 !== e.err || m_enable2 !== 1'b0 || rdata2 !== e.rdata)
      $display("FAIL to_status got err=%b en=%b rdata=%h want %b 0 %h", err2, m_enable2, rdata2, e.err, e.rdata);
    else n_pass++;
    n_chk++;
    if (m_addr2 !== e.addr || m_data_in2 !== e.wdata || m_rw2 !== 1'b0)
      $display("FAIL to_fields got %h/%h/%b want %h/%h/0", m_addr2, m_data_in2, m_rw2, e.addr, e.wdata);
    else n_pass++;
    req2 = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    bit hit;
    bit seen;
    req_addr[6:0]  = 7'h0F;
    req_wdata[7:0] = 8'hF0;
    req_rw[0]      = 1'b0;
    mdl_lat        = 50;
    req = 2'b01;
    wait_grant(10, hit);
    repeat (5) @(negedge clk);
    n_chk++;
    if (!hit || busy !== 1'b1 || m_enable !== 1'b0 || grant !== 2'b01)
      $display("FAIL rw_inwait got busy=%b en=%b grant=%b want 1 0 01", busy, m_enable, grant);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (grant !== 2'b00 || m_enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL rw_async got grant=%b en=%b busy=%b want 00 0 0", grant, m_enable, busy);
    else n_pass++;
    req = 2'b00;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00) seen = 1'b1;
    end
    rst = 1'b0;
    rd_hold = '0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00) seen = 1'b1;
    end
    n_chk++;
    if (seen)
      $display("FAIL rw_nodone got a done pulse want none");
    else n_pass++;
    req_addr[6:0]  = 7'h45;
    req_wdata[7:0] = 8'h99;
    mdl_lat        = 2;
    sb.push_back('{owner: 2'b01, addr: 7'h45, wdata: 8'h99, rdata: rd_hold, err: 1'b0});
    req = 2'b01;
    wait_done(50, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner || m_addr !== e.addr || m_data_in !== e.wdata || err !== e.err || rdata !== e.rdata)
      $display("FAIL rw_next got %b/%h/%h/%b/%h want %b/%h/%h/%b/%h",
               done, m_addr, m_data_in, err, rdata, e.owner, e.addr, e.wdata, e.err, e.rdata);
    else n_pass++;
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_master_busy();
    bit hit;
    bit seen;
    mdl_force_busy = 1'b1;
    @(negedge clk);
    req_addr[6:0]  = 7'h12;
    req_wdata[7:0] = 8'h34;
    req_rw[0]      = 1'b0;
    mdl_lat        = 3;
    sb.push_back('{owner: 2'b01, addr: 7'h12, wdata: 8'h34, rdata: rd_hold, err: 1'b0});
    req = 2'b01;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (grant !== 2'b00 || busy !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen)
      $display("FAIL mb_hold got a grant while master busy want none");
    else n_pass++;
    mdl_force_busy = 1'b0;
    wait_grant(5, hit);
    n_chk++;
    if (!hit || grant !== 2'b01)
      $display("FAIL mb_grant got %b want 01", grant);
    else n_pass++;
    wait_done(50, hit);
    e = sb.pop_front();
    n_chk++;
    if (!hit || done !== e.owner || m_addr !== e.addr || m_data_in !== e.wdata || rdata !== e.rdata)
      $display("FAIL mb_done got %b/%h/%h/%h want %b/%h/%h/%h",
               done, m_addr, m_data_in, rdata, e.owner, e.addr, e.wdata, e.rdata);
    else n_pass++;
    req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_tie();
    test_timeout();
    test_reset_in_wait();
    test_master_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
